iomem_mailbox: RTL and testbench
================================

Name: iomem_mailbox

Overview:
- Responder on the SoC iomem bus, i.e. the peripheral end of the CPU-initiated valid/ready memory interface.
- Gives firmware a word-wide bidirectional mailbox: CPU writes push into a TX FIFO drained by an external stream sink; an external stream source fills an RX FIFO that CPU reads pop.
- Provides a status register and a level interrupt suitable for one of the irq_5..irq_7 inputs.

Parameters:
BASE_ADDR, 32'h0300_0000, base of the 16-byte register window; bits [3:0] must be zero.
DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
iomem_valid  in  1  CPU request; held high until iomem_ready is seen
iomem_ready  out  1  one-cycle response pulse
iomem_wstrb  in  4  byte write strobes; 0 means read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data; valid while iomem_ready=1
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  sink accepts tx_data this cycle
tx_data  out  32  TX FIFO head word
rx_valid  in  1  source offers rx_data
rx_ready  out  1  RX FIFO not full
rx_data  in  32  word to push
irq  out  1  registered level interrupt

Behaviour:
- Decode: sel = iomem_valid && iomem_addr[31:4]==BASE_ADDR[31:4]. Outside the window the block never asserts ready.
- Offsets:
  - 0x0 DATA: write pushes wdata to TX (any wstrb bit set, full word); read pops RX.
  - 0x4 STATUS: read-only. [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count, others 0.
  - 0x8 IRQ_EN: bits [1:0]; written only when wstrb[0]=1; other bits read 0.
  - 0xC: reads 0; writes ignored.
- FSM states IDLE and RESP:
  - IDLE, sel=1:
    - Write to DATA with tx_full=1: stay IDLE, ready stays 0 (wait state). Retry every cycle until space frees.
    - Otherwise: perform the access, register rdata, set ready<=1, go to RESP.
  - RESP: ready<=0, go to IDLE. sel is ignored in RESP, so one request is never serviced twice.
- Latency: ready high in the cycle after valid is first sampled, when no wait state applies.
- Read of DATA with rx_empty=1: rdata=32'hFFFF_FFFF, no pop, normal latency.
- rdata is 0 whenever ready=0.
- Streams:
  - tx_valid = !tx_empty; tx_data = head entry.
  - Pop on tx_valid && tx_ready.
  - rx_ready = !rx_full, with no combinational path from the same-cycle CPU pop.
  - Push on rx_valid && rx_ready.
- Simultaneous push and pop on the same FIFO in one cycle: both occur, count unchanged, pointers wrap modulo DEPTH.
  - On a full TX, a CPU write still waits even if tx_ready pops that cycle; it completes next cycle.
- Counts are log2(DEPTH)+1 bits, zero-extended into their 8-bit STATUS fields.
- irq is registered: irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty), using post-update FIFO state.
- Reset, including mid-transaction: state IDLE, ready=0, rdata=0, both FIFOs empty, irq_en=0, irq=0, tx_valid=0, rx_ready=1.
  - A request still held after reset is serviced afresh.
- FIFO storage contents are not reset.

Test Plan:
- After reset, read 0x0300_0004 -> ready one cycle after valid, rdata=32'h0000_0006 (tx_empty, rx_empty). Read 0x0300_0000 -> rdata=32'hFFFF_FFFF.
- tx_ready=0; write 8 words 0x11..0x18 to DATA -> each ready in 1 cycle, STATUS=32'h0000_0805. A 9th write stalls. Raise tx_ready for 1 cycle -> tx_data=0x11 popped; the 9th write completes the next cycle. Drain order is 0x12..0x18 then the 9th word.
- Source pushes 0xA5A5_0001..0xA5A5_0008 -> rx_ready drops after the 8th. CPU reads return them in order; rx_ready rises the cycle after the first pop.
- Write IRQ_EN=1 while RX empty -> irq=0. Push 1 RX word -> irq=1 two cycles after rx handshake. CPU pop -> irq=0. Write IRQ_EN=2 with TX empty -> irq=1.
- Same-cycle rx push and CPU DATA pop with rx_count=3 -> rx_count stays 3, data ordering preserved; repeat across pointer wrap (>16 transfers).
- Assert reset during a stalled full-TX write -> tx_valid=0, STATUS=32'h0000_0006, ready=0. After reset release the held write completes in 1 cycle. An address outside the window (0x0300_0010) -> ready never asserts.

Source files
------------

// File: rtl/iomem_mailbox_if.sv
// rtl/iomem_mailbox_if.sv - iomem valid/ready request bus bundle
//
// Purpose: groups the CPU-initiated iomem request/response signals.
// Ports (signals):
//   valid  master->slave  request held until ready
//   ready  slave->master  one-cycle response pulse
//   wstrb  master->slave  byte write strobes, 0 = read
//   addr   master->slave  byte address
//   wdata  master->slave  write data
//   rdata  slave->master  read data, valid while ready=1
interface iomem_mailbox_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid,
    output wstrb,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wstrb,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );
endinterface

// File: rtl/iomem_mailbox.sv
// rtl/iomem_mailbox.sv - iomem responder with TX/RX word FIFOs, status and irq
//
// Purpose: CPU writes to DATA push into the TX FIFO (drained by tx_* sink),
// the rx_* source fills the RX FIFO which CPU reads of DATA pop.
// Register window (16 bytes at BASE_ADDR):
//   0x0 DATA    write pushes TX, read pops RX (0xFFFF_FFFF when RX empty)
//   0x4 STATUS  [0] tx_full [1] tx_empty [2] rx_empty [3] rx_full
//               [15:8] tx_count [23:16] rx_count
//   0x8 IRQ_EN  [1:0], [0] rx not empty, [1] tx empty
//   0xC         reads 0, writes ignored
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   bus              iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//   tx_valid/ready/data  TX stream out, head of TX FIFO
//   rx_valid/ready/data  RX stream in, pushes into RX FIFO
//   irq              registered level interrupt
module iomem_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          DEPTH     = 8
) (
  input  logic             clk,
  input  logic             reset,
  iomem_mailbox_if.slave   bus,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [31:0]      tx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [31:0]      rx_data,
  output logic             irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Bus-side registered state
  state_t      state;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [1:0]  irq_en;
  logic        irq_q;

  // FIFO state; storage is intentionally not reset
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  // Request decode
  logic       sel, is_write, wait_full, accept;
  logic [1:0] off;
  assign sel      = bus.valid && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign is_write = |bus.wstrb;
  assign off      = bus.addr[3:2];
  // Write to a full TX stalls using the current count, so a same-cycle
  // sink pop does not let the write in until the following cycle.
  assign wait_full = (off == 2'd0) && is_write && tx_full;
  assign accept    = (state == IDLE) && sel && !wait_full;

  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];

  // FIFO handshakes
  logic cpu_push, cpu_pop, tx_pop, rx_push;
  assign cpu_push = accept && is_write && (off == 2'd0);
  assign cpu_pop  = accept && !is_write && (off == 2'd0) && !rx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  // Depends only on registered count, never on the same-cycle CPU pop
  assign rx_ready = !rx_full;

  logic [CW-1:0] tx_count_nxt, rx_count_nxt;
  assign tx_count_nxt = tx_count + {{AW{1'b0}}, cpu_push} - {{AW{1'b0}}, tx_pop};
  assign rx_count_nxt = rx_count + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, cpu_pop};

  logic       irq_en_wr;
  logic [1:0] irq_en_nxt;
  logic       irq_nxt;
  assign irq_en_wr  = accept && is_write && (off == 2'd2) && bus.wstrb[0];
  assign irq_en_nxt = irq_en_wr ? bus.wdata[1:0] : irq_en;
  // Evaluated on post-update FIFO and enable state
  assign irq_nxt = (irq_en_nxt[0] && (rx_count_nxt != '0)) ||
                   (irq_en_nxt[1] && (tx_count_nxt == '0));

  // Read data mux
  logic [31:0] status;
  logic [31:0] rd_val;
  assign status = {8'h00, 8'(rx_count), 8'(tx_count), 4'h0,
                   rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rd_val = 32'h0;
    case (off)
      2'd0:    rd_val = rx_empty ? 32'hFFFF_FFFF : rx_mem[rx_rd_ptr];
      2'd1:    rd_val = status;
      2'd2:    rd_val = {30'h0, irq_en};
      default: rd_val = 32'h0;
    endcase
  end

  // Bus FSM with registered ready/rdata; RESP ignores sel so a held
  // request is not serviced twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      irq_en  <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt;
      irq_q  <= irq_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b1;
            rdata_q <= is_write ? 32'h0 : rd_val;
            state   <= RESP;
          end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          rdata_q <= 32'h0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

  // FIFO pointers and counts; pointers wrap modulo DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
    end else begin
      if (cpu_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)   tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_push)  rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (cpu_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      tx_count <= tx_count_nxt;
      rx_count <= rx_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_push) tx_mem[tx_wr_ptr] <= bus.wdata;
    if (rx_push)  rx_mem[rx_wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_iomem_mailbox.sv
// tb/tb_iomem_mailbox.sv - scoreboard testbench for iomem_mailbox
module tb_iomem_mailbox;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [31:0] tx_data, rx_data;

  always #5 clk = ~clk;

  iomem_mailbox_if bus_if ();

  iomem_mailbox #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .irq      (irq)
  );

  int total = 0;
  int bad   = 0;
  int rdata_viol = 0;
  bit mon_on = 0;

  // Scoreboards: bus responses, TX stream words, RX model contents
  logic [32:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] tx_q  [$];
  logic [31:0] rx_q  [$];

  logic [32:0] mon_e;
  string       mon_t;
  logic [31:0] mon_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (!bus_if.ready && bus_if.rdata !== 32'h0) rdata_viol++;
      if (bus_if.ready) begin
        if (exp_q.size() == 0) chk("unexp_ready", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          mon_t = tag_q.pop_front();
          if (mon_e[32]) chk(mon_t, bus_if.rdata, mon_e[31:0]);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexp", tx_data, 32'h0);
        else begin
          mon_w = tx_q.pop_front();
          chk("tx_data", tx_data, mon_w);
        end
      end
    end
  end

  task automatic cpu_access(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input logic is_read, input logic [31:0] exp,
                            input logic want_resp, input int max_cyc, output int lat);
    @(posedge clk); #1;
    if (want_resp) begin
      exp_q.push_back({is_read, exp});
      tag_q.push_back(tag);
    end
    bus_if.valid = 1'b1;
    bus_if.addr  = addr;
    bus_if.wstrb = wstrb;
    bus_if.wdata = wdata;
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (bus_if.ready) begin
        lat = i;
        break;
      end
    end
    bus_if.valid = 1'b0;
    bus_if.wstrb = 4'h0;
    if (want_resp && lat < 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
    int lat;
    cpu_access(tag, BASE | {28'h0, off}, 4'h0, 32'h0, 1'b1, exp, 1'b1, 20, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wr(input string tag, input logic [3:0] off, input logic [31:0] data,
                    input logic [3:0] strb);
    int lat;
    cpu_access(tag, BASE | {28'h0, off}, strb, data, 1'b0, 32'h0, 1'b1, 20, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wr_data(input string tag, input logic [31:0] w, input int max_cyc, output int lat);
    tx_q.push_back(w);
    cpu_access(tag, BASE, 4'hF, w, 1'b0, 32'h0, 1'b1, max_cyc, lat);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    if (rx_q.size() != 0) e = rx_q.pop_front();
    else e = 32'hFFFF_FFFF;
    rd(tag, 4'h0, e);
  endtask

  task automatic rx_push_word(input logic [31:0] w);
    bit done = 0;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = w;
    for (int i = 0; i < 30; i++) begin
      if (rx_ready) begin
        @(posedge clk); #1;
        rx_q.push_back(w);
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!done) chk("rx_push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_tx(input string tag);
    int n = 0;
    tx_ready = 1'b1;
    while (tx_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    chk({tag, "_left"}, 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset        = 1'b1;
    bus_if.valid = 1'b0;
    bus_if.wstrb = 4'h0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, bus_if.ready}, 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'h0);
    chk("rst_txv", {31'h0, tx_valid}, 32'd0);
    chk("rst_rxr", {31'h0, rx_ready}, 32'd1);
    chk("rst_irq", {31'h0, irq}, 32'd0);
    reset  = 1'b0;
    mon_on = 1;

    // Basic register reads
    rd("status_rst", 4'h4, 32'h0000_0006);
    rd_data("rx_empty_rd");
    rd("irqen_rst", 4'h8, 32'h0);
    wr("wr_off_c", 4'hC, 32'hFFFF_FFFF, 4'hF);
    rd("rd_off_c", 4'hC, 32'h0);
    rd("status_after_c", 4'h4, 32'h0000_0006);

    // TX fill, stall on full, release by one sink pop
    for (int i = 0; i < 8; i++) begin
      wr_data("tx_fill", 32'h11 + i, 20, lat);
      chk("tx_fill_lat", 32'(lat), 32'd1);
    end
    rd("status_txfull", 4'h4, 32'h0000_0805);
    fork
      begin
        wr_data("tx_w9", 32'h0000_0099, 50, lat);
        chk("tx_w9_lat", 32'(lat), 32'd5);
      end
      begin
        @(posedge clk); #1;
        repeat (3) begin
          @(posedge clk); #1;
          chk("tx_stall_ready", {31'h0, bus_if.ready}, 32'd0);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk("tx_popcycle_ready", {31'h0, bus_if.ready}, 32'd0);
        @(posedge clk); #1;
        chk("tx_next_ready", {31'h0, bus_if.ready}, 32'd1);
      end
    join
    drain_tx("tx_drain1");
    rd("status_txdrained", 4'h4, 32'h0000_0006);

    // RX fill to full, CPU reads in order
    for (int i = 0; i < 8; i++) rx_push_word(32'hA5A5_0001 + i);
    chk("rx_full_rdy", {31'h0, rx_ready}, 32'd0);
    rd("status_rxfull", 4'h4, 32'h0008_000A);
    rd_data("rx_pop0");
    chk("rx_rdy_rise", {31'h0, rx_ready}, 32'd1);
    for (int i = 1; i < 8; i++) rd_data("rx_pop");
    rd("status_rxdrained", 4'h4, 32'h0000_0006);

    // Interrupt behaviour
    wr("irqen_w1", 4'h8, 32'h1, 4'hF);
    chk("irq_en1_empty", {31'h0, irq}, 32'd0);
    rx_push_word(32'hBEEF_0001);
    @(posedge clk); #1;
    chk("irq_rx_word", {31'h0, irq}, 32'd1);
    rd_data("irq_pop");
    chk("irq_after_pop", {31'h0, irq}, 32'd0);
    wr("irqen_w2", 4'h8, 32'h2, 4'hF);
    chk("irq_tx_empty", {31'h0, irq}, 32'd1);
    rd("irqen_rd2", 4'h8, 32'h2);
    wr("irqen_nostrb0", 4'h8, 32'h0, 4'b0010);
    rd("irqen_keep2", 4'h8, 32'h2);

    // Same-cycle RX push and CPU pop, across pointer wrap
    for (int i = 0; i < 3; i++) rx_push_word(32'hC0DE_0000 + i);
    for (int k = 0; k < 20; k++) begin
      fork
        rd_data("sc_pop");
        rx_push_word(32'hD000_0000 + k);
      join
      rd("sc_status", 4'h4, 32'h0003_0002);
    end
    for (int i = 0; i < 3; i++) rd_data("sc_tail");
    rd_data("sc_empty");

    // Reset during a stalled full-TX write
    for (int i = 0; i < 8; i++) begin
      wr_data("rr_fill", 32'h5A00_0000 + i, 20, lat);
      chk("rr_fill_lat", 32'(lat), 32'd1);
    end
    fork
      wr_data("rr_w9", 32'h5A00_00FF, 30, lat);
      begin
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tx_q.delete();
        tx_q.push_back(32'h5A00_00FF);
        rx_q.delete();
        @(posedge clk); #1;
        chk("rr_txv", {31'h0, tx_valid}, 32'd0);
        chk("rr_ready", {31'h0, bus_if.ready}, 32'd0);
        chk("rr_rxr", {31'h0, rx_ready}, 32'd1);
        chk("rr_irq", {31'h0, irq}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rr_held_done", {31'h0, bus_if.ready}, 32'd1);
      end
    join
    rd("rr_status", 4'h4, 32'h0000_0104);
    drain_tx("rr_drain");
    chk("rr_irqen_cleared", {31'h0, irq}, 32'd0);
    rd("rr_irqen", 4'h8, 32'h0);

    // Outside the window: never answered
    cpu_access("oow_rd", BASE + 32'h10, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, 10, lat);
    chk("oow_rd_ready", 32'(lat), 32'hFFFF_FFFF);
    cpu_access("oow_wr", BASE + 32'h10, 4'hF, 32'h1234, 1'b0, 32'h0, 1'b0, 10, lat);
    chk("oow_wr_ready", 32'(lat), 32'hFFFF_FFFF);
    rd("status_final", 4'h4, 32'h0000_0006);

    repeat (2) @(posedge clk);
    #1;
    chk("resp_left", 32'(exp_q.size()), 32'd0);
    chk("tx_left", 32'(tx_q.size()), 32'd0);
    chk("rdata_idle_zero", 32'(rdata_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
